// File: rtl/sensor_uart_streamer.sv
// Samples debounced 1-bit sensor channels periodically or on change and streams
// them as 4-byte 8N1 UART frames: A5, status, seq, XOR checksum.
module sensor_uart_streamer #(
  parameter int NUM_CH        = 4,
  parameter int CLK_DIV       = 1250,
  parameter int SAMPLE_PERIOD = 1048576,
  parameter int DEB_CYCLES    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] sensor_in,
  input  logic              mode_evt,
  output logic              uarttx,
  output logic              busy,
  output logic [NUM_CH-1:0] sensor_state,
  output logic [7:0]        drop_cnt
);

  localparam int BW = $clog2(CLK_DIV);
  localparam int TW = $clog2(SAMPLE_PERIOD);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(SAMPLE_PERIOD - 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_nxt;
  logic [NUM_CH-1:0] sync1, sync2, deb_nxt;
  logic [DW-1:0]     deb_cnt [NUM_CH];
  logic [TW-1:0]     timer;
  logic              mode_q;
  logic [BW-1:0]     baud;
  logic [2:0]        bit_idx;
  logic [1:0]        byte_idx;
  logic [7:0]        seq, status_l, seq_l, status_nxt, cur_byte;
  logic              tick, trig, bit_end;

  always_comb begin
    deb_nxt = sensor_state;
    for (int i = 0; i < NUM_CH; i++)
      if (sync2[i] != sensor_state[i] && deb_cnt[i] == DEB_MAX) deb_nxt[i] = sync2[i];
  end

  always_comb begin
    status_nxt = '0;
    status_nxt[NUM_CH-1:0] = deb_nxt;
  end

  assign tick    = (timer == TIMER_MAX);
  assign trig    = mode_q ? (deb_nxt != sensor_state) : tick;
  assign bit_end = (baud == BAUD_MAX);

  // Input synchronisers, debouncers, sample timer and mode register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1        <= '0;
      sync2        <= '0;
      sensor_state <= '0;
      timer        <= '0;
      mode_q       <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) deb_cnt[i] <= '0;
    end else begin
      sync1        <= sensor_in;
      sync2        <= sync1;
      sensor_state <= deb_nxt;
      timer        <= tick ? '0 : timer + TW'(1);
      mode_q       <= mode_evt;
      for (int i = 0; i < NUM_CH; i++)
        deb_cnt[i] <= (sync2[i] == sensor_state[i] || deb_cnt[i] == DEB_MAX) ?
                      '0 : deb_cnt[i] + DW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trig) state_nxt = START;
      START:   if (bit_end) state_nxt = DATA;
      DATA:    if (bit_end && bit_idx == 3'd7) state_nxt = STOP;
      STOP:    if (bit_end) state_nxt = (byte_idx == 2'd3) ? IDLE : START;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Bit/byte counters, sequence number and drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud     <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      seq      <= '0;
      drop_cnt <= '0;
    end else begin
      baud     <= (state == IDLE || bit_end) ? '0 : baud + BW'(1);
      if (state != DATA)  bit_idx <= '0;
      else if (bit_end)   bit_idx <= bit_idx + 3'd1;
      if (state == IDLE)                byte_idx <= '0;
      else if (state == STOP && bit_end) byte_idx <= byte_idx + 2'd1;
      if (state == STOP && bit_end && byte_idx == 2'd3) seq <= seq + 8'd1;
      if (trig && state != IDLE && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Frame payload captured on the accepting cycle; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (trig && state == IDLE) begin
      status_l <= status_nxt;
      seq_l    <= seq;
    end
  end

  always_comb begin
    case (byte_idx)
      2'd0:    cur_byte = 8'hA5;
      2'd1:    cur_byte = status_l;
      2'd2:    cur_byte = seq_l;
      default: cur_byte = 8'hA5 ^ status_l ^ seq_l;
    endcase
  end

  always_comb begin
    uarttx = 1'b1;
    case (state)
      START:   uarttx = 1'b0;
      DATA:    uarttx = cur_byte[bit_idx];
      default: uarttx = 1'b1;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sensor_uart_streamer.sv
// Directed/randomized bench: decodes every frame cycle-by-cycle against an ideal
// 8N1 waveform built from the expected bytes, and checks drop/debounce behaviour.
module tb_sensor_uart_streamer;
  localparam int NUM_CH = 4;
  localparam int CLK_DIV = 4;
  localparam int SP = 200;
  localparam int DEB = 3;
  localparam int FRAME = 40 * CLK_DIV;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] sensor_in;
  logic              mode_evt;
  logic              uarttx, busy;
  logic [NUM_CH-1:0] sensor_state;
  logic [7:0]        drop_cnt;

  int checks = 0;
  int failures = 0;
  int starts = 0;
  logic busy_d = 1'b0;

  always #5 clk = ~clk;

  sensor_uart_streamer #(
    .NUM_CH(NUM_CH), .CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(SP), .DEB_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sensor_in(sensor_in), .mode_evt(mode_evt),
    .uarttx(uarttx), .busy(busy), .sensor_state(sensor_state), .drop_cnt(drop_cnt)
  );

  // count frame starts as rising edges of busy
  always @(negedge clk) begin
    if (busy === 1'b1 && busy_d === 1'b0) starts++;
    busy_d = busy;
  end

  task automatic chk(input logic [159:0] obs, input logic [159:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] frame_of(input logic [7:0] st, input logic [7:0] sq);
    return {8'hA5 ^ st ^ sq, sq, st, 8'hA5};
  endfunction

  // ideal line waveform, one entry per clock, start bit first, data LSB first
  function automatic logic [159:0] wave_of(input logic [31:0] f);
    logic [159:0] w;
    logic [7:0] b;
    logic v;
    w = '1;
    for (int k = 0; k < 4; k++) begin
      b = f[8*k +: 8];
      for (int j = 0; j < 10; j++) begin
        v = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : b[j-1];
        for (int c = 0; c < CLK_DIV; c++) w[(k*10+j)*CLK_DIV + c] = v;
      end
    end
    return w;
  endfunction

  task automatic wait_busy(input int limit, output bit ok);
    int t = 0;
    while (busy !== 1'b1 && t < limit) begin @(negedge clk); t++; end
    ok = (busy === 1'b1);
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int t = 0;
    while (busy !== 1'b0 && t < limit) begin @(negedge clk); t++; end
    chk(busy, 1'b0, {tag, "_idle_timeout"});
  endtask

  task automatic capture(input logic [31:0] f, input string tag);
    logic [159:0] w, bw;
    bit ok;
    wait_busy(2000, ok);
    if (!ok) begin
      chk(1'b0, 1'b1, {tag, "_start_timeout"});
      return;
    end
    for (int i = 0; i < FRAME; i++) begin
      w[i] = uarttx;
      bw[i] = busy;
      @(negedge clk);
    end
    chk(w, wave_of(f), tag);
    chk(bw, {160{1'b1}}, {tag, "_busy_high"});
    chk(busy, 1'b0, {tag, "_busy_fall"});
  endtask

  task automatic do_reset(input logic mode, input logic [NUM_CH-1:0] s);
    rst_n = 1'b0;
    mode_evt = mode;
    sensor_in = s;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] seq_model;
    logic [NUM_CH-1:0] v;
    int n, s0;
    bit ok;

    rst_n = 1'b0;
    mode_evt = 1'b0;
    sensor_in = 4'b0101;
    @(negedge clk);
    chk(uarttx, 1'b1, "reset_uarttx");
    chk(busy, 1'b0, "reset_busy");
    chk(drop_cnt, 8'd0, "reset_drop");
    chk(sensor_state, 4'd0, "reset_state");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // periodic mode, fixed pattern
    capture(frame_of(8'h05, 8'h00), "per_f0");
    capture(frame_of(8'h05, 8'h01), "per_f1");
    chk(sensor_state, 4'b0101, "per_state");

    // reset in the middle of a frame
    v = NUM_CH'($urandom_range(0, 15));
    sensor_in = v;
    wait_busy(2000, ok);
    chk(ok, 1'b1, "mid_rst_start_timeout");
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk(uarttx, 1'b1, "mid_rst_uarttx");
    chk(busy, 1'b0, "mid_rst_busy");
    chk(sensor_state, 4'd0, "mid_rst_state");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    capture(frame_of({4'd0, v}, 8'h00), "mid_rst_seq0");

    // event mode: short glitch rejected, 6-cycle pulse gives rise frame, fall dropped while busy
    do_reset(1'b1, 4'd0);
    repeat (10) @(negedge clk);
    s0 = starts;
    sensor_in[0] = 1'b1;
    repeat (2) @(negedge clk);
    sensor_in[0] = 1'b0;
    repeat (30) @(negedge clk);
    chk(starts - s0, 0, "evt_glitch_frames");
    chk(sensor_state, 4'd0, "evt_glitch_state");
    fork
      capture(frame_of(8'h01, 8'h00), "evt_rise");
      begin
        sensor_in[0] = 1'b1;
        repeat (6) @(negedge clk);
        sensor_in[0] = 1'b0;
      end
    join
    chk(drop_cnt, 8'd1, "evt_fall_dropped");
    chk(sensor_state, 4'd0, "evt_fall_state");

    // event mode, changes every 30 cycles: one accepted then five dropped, repeating
    do_reset(1'b1, 4'd0);
    repeat (10) @(negedge clk);
    n = $urandom_range(6, 18);
    s0 = starts;
    for (int i = 0; i < n; i++) begin
      sensor_in[1] = ~sensor_in[1];
      repeat (30) @(negedge clk);
    end
    wait_idle(400, "toggle30");
    chk(drop_cnt, 8'(n - (n + 5) / 6), "toggle30_drops");
    chk(starts - s0, (n + 5) / 6, "toggle30_frames");

    // saturation of the drop counter
    for (int i = 0; i < 400; i++) begin
      sensor_in[2] = ~sensor_in[2];
      repeat (8) @(negedge clk);
    end
    wait_idle(400, "sat");
    chk(drop_cnt, 8'hFF, "drop_saturate");

    // long periodic run with random status, seq wraps FF -> 00
    v = NUM_CH'($urandom_range(0, 15));
    do_reset(1'b0, v);
    seq_model = 8'h00;
    for (int f = 0; f < 257; f++) begin
      capture(frame_of({4'd0, v}, seq_model), $sformatf("per_long%0d", f));
      seq_model = seq_model + 8'd1;
      v = NUM_CH'($urandom_range(0, 15));
      sensor_in = v;
    end
    chk(drop_cnt, 8'd0, "per_long_no_drops");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
